// File: rtl/simple_bus_pkg.sv
// Shared types and widths for the multi-master bus arbiter.
package simple_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_READ  = 2'b00,
        MODE_WRITE = 2'b01
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last+1 upward with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int cand;

    always_comb begin
        logic found;
        gnt   = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter giving NUM_MASTERS masters shared access to one slave,
// with per-transfer timeout and reserved-mode rejection.
module simple_bus_arbiter
    import simple_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_MASTERS-1:0]              m_req,
    input  logic [NUM_MASTERS-1:0]              m_start,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
    input  logic [NUM_MASTERS-1:0][1:0]         m_mode,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata,
    output logic [NUM_MASTERS-1:0]              m_gnt,
    output logic [NUM_MASTERS-1:0]              m_rdy,
    output logic                                m_err,
    output logic [DATA_W-1:0]                   m_rdata,
    output logic                                s_req,
    input  logic                                s_gnt,
    output logic                                s_start,
    output logic [ADDR_W-1:0]                   s_addr,
    output logic [1:0]                          s_mode,
    output logic [DATA_W-1:0]                   s_wdata,
    input  logic [DATA_W-1:0]                   s_rdata,
    input  logic                                s_rdy,
    output logic [1:0]                          dbg_state
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // Handshake: m_req asks for the bus, m_gnt (one-hot) answers one cycle later;
    // the owner pulses m_start once, the slave sees s_start once s_gnt allows it,
    // s_rdy ends the transfer and m_rdy/m_err/m_rdata pulse to the owner one cycle later.
    state_t                  state, state_nxt;
    logic [IW-1:0]           owner, owner_nxt;
    logic [IW-1:0]           last_owner, last_nxt;
    logic [NUM_MASTERS-1:0]  gnt_nxt, rdy_nxt, owner_oh;
    logic                    s_req_nxt, s_start_nxt, err_nxt;
    logic [DATA_W-1:0]       rdata_nxt, wdata_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [1:0]              mode_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic                    pend, pend_nxt;
    logic                    done;
    logic [NUM_MASTERS-1:0]  win_gnt;
    logic [IW-1:0]           win_idx;

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr (
        .req  (m_req),
        .last (last_owner),
        .gnt  (win_gnt),
        .idx  (win_idx)
    );

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    assign dbg_state = state;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last_owner;
        gnt_nxt     = m_gnt;
        s_req_nxt   = s_req;
        s_start_nxt = 1'b0;
        rdy_nxt     = '0;
        err_nxt     = 1'b0;
        rdata_nxt   = m_rdata;
        addr_nxt    = s_addr;
        mode_nxt    = s_mode;
        wdata_nxt   = s_wdata;
        cnt_nxt     = cnt;
        pend_nxt    = pend;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (|m_req) begin
                    owner_nxt = win_idx;
                    last_nxt  = win_idx;
                    gnt_nxt   = win_gnt;
                    s_req_nxt = 1'b1;
                    pend_nxt  = 1'b0;
                    state_nxt = GRANTED;
                end
            end
            GRANTED: begin
                // A start waiting on s_gnt is committed; a late req drop cannot cancel it.
                if (pend) begin
                    if (s_gnt) begin
                        s_start_nxt = 1'b1;
                        pend_nxt    = 1'b0;
                        cnt_nxt     = 8'd1;
                        state_nxt   = BUSY;
                    end
                end else if (m_start[owner]) begin
                    if (m_mode[owner] != MODE_READ && m_mode[owner] != MODE_WRITE) begin
                        done      = 1'b1;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end else begin
                        addr_nxt  = m_addr[owner];
                        mode_nxt  = m_mode[owner];
                        wdata_nxt = m_wdata[owner];
                        if (s_gnt) begin
                            s_start_nxt = 1'b1;
                            cnt_nxt     = 8'd1;
                            state_nxt   = BUSY;
                        end else begin
                            pend_nxt = 1'b1;
                        end
                    end
                end else if (!m_req[owner]) begin
                    gnt_nxt   = '0;
                    s_req_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                // cnt holds the number of busy cycles including the current one,
                // so s_rdy in the cycle it equals TIMEOUT still wins.
                if (s_rdy) begin
                    done      = 1'b1;
                    rdata_nxt = s_rdata;
                end else if (cnt == TIMEOUT_CNT) begin
                    done      = 1'b1;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (done) begin
            rdy_nxt   = owner_oh;
            gnt_nxt   = '0;
            s_req_nxt = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NUM_MASTERS - 1);
            m_gnt      <= '0;
            m_rdy      <= '0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
            s_req      <= 1'b0;
            s_start    <= 1'b0;
            s_addr     <= '0;
            s_mode     <= '0;
            s_wdata    <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
            m_gnt      <= gnt_nxt;
            m_rdy      <= rdy_nxt;
            m_err      <= err_nxt;
            m_rdata    <= rdata_nxt;
            s_req      <= s_req_nxt;
            s_start    <= s_start_nxt;
            s_addr     <= addr_nxt;
            s_mode     <= mode_nxt;
            s_wdata    <= wdata_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Directed bench for simple_bus_arbiter: driver tasks push expectations,
// a negedge monitor pops and compares grants, slave starts and completions.
module tb_simple_bus_arbiter;
    import simple_bus_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      m_req = '0;
    logic [N-1:0]      m_start = '0;
    logic [N-1:0][7:0] m_addr = '0;
    logic [N-1:0][1:0] m_mode = '0;
    logic [N-1:0][7:0] m_wdata = '0;
    logic [N-1:0]      m_gnt, m_rdy;
    logic              m_err;
    logic [7:0]        m_rdata;
    logic              s_req, s_start;
    logic              s_gnt = 1'b1;
    logic [7:0]        s_addr, s_wdata;
    logic [1:0]        s_mode;
    logic [7:0]        s_rdata = '0;
    logic              s_rdy = 1'b0;
    logic [1:0]        dbg_state;

    logic [3:0]  gnt_q[$];
    logic [17:0] start_q[$];
    logic [13:0] rdy_q[$];
    int n_checks = 0;
    int n_errors = 0;

    simple_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_start(m_start), .m_addr(m_addr), .m_mode(m_mode), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rdy(m_rdy), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_gnt(s_gnt), .s_start(s_start), .s_addr(s_addr), .s_mode(s_mode),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rdy(s_rdy), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {27'b0, m_gnt, m_rdy, m_err, m_rdata, s_req, s_start, s_addr, s_mode, s_wdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    initial begin
        logic [N-1:0] prev_gnt;
        logic [3:0]   eg;
        logic [17:0]  es;
        logic [13:0]  er;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (m_gnt != '0 && prev_gnt == '0) begin
                if (gnt_q.size() == 0) check("gnt_unexpected", 64'(m_gnt), 64'(0));
                else begin
                    eg = gnt_q.pop_front();
                    check("gnt_order", 64'(m_gnt), 64'(eg));
                end
            end
            prev_gnt = m_gnt;
            if (s_start) begin
                if (start_q.size() == 0) check("s_start_unexpected", 64'(s_start), 64'(0));
                else begin
                    es = start_q.pop_front();
                    check("s_start_fields", 64'({s_addr, s_mode, s_wdata}), 64'(es));
                end
            end
            if (m_rdy != '0) begin
                if (rdy_q.size() == 0) check("rdy_unexpected", 64'(m_rdy), 64'(0));
                else begin
                    er = rdy_q.pop_front();
                    check("rdy_owner", 64'(m_rdy), 64'(er[12:9]));
                    check("rdy_err", 64'(m_err), 64'(er[8]));
                    if (er[13]) check("rdy_data", 64'(m_rdata), 64'(er[7:0]));
                end
            end
        end
    end

    // driver tasks
    task automatic wait_gnt(input int m);
        int w;
        gnt_q.push_back(4'(1 << m));
        w = 0;
        do begin
            tick();
            w++;
        end while (m_gnt[m] !== 1'b1 && w < 20);
        check("req_to_gnt", 64'(w), 64'(1));
    endtask

    // Called in the grant cycle; rdy_at is the busy cycle (0 = s_start cycle) that carries s_rdy.
    task automatic do_txn(input int m, input logic [7:0] addr, input logic [1:0] mode,
                          input logic [7:0] wdata, input int rdy_at, input logic [7:0] rdata,
                          input int exp_cycles, input logic exp_err, input bit hold);
        int n;
        start_q.push_back({addr, mode, wdata});
        rdy_q.push_back({1'b1, 4'(1 << m), exp_err, exp_err ? 8'h00 : rdata});
        m_addr[m]  = addr;
        m_mode[m]  = mode;
        m_wdata[m] = wdata;
        m_start[m] = 1'b1;
        tick();
        m_start[m] = 1'b0;
        if (!hold) m_req[m] = 1'b0;
        check("start_to_s_start", 64'(s_start), 64'(1));
        n = 0;
        while (m_rdy[m] !== 1'b1 && n < 40) begin
            if (n == 1) check("s_addr_held", 64'(s_addr), 64'(addr));
            s_rdy   = (n == rdy_at);
            s_rdata = rdata;
            tick();
            n++;
        end
        s_rdy = 1'b0;
        check("s_start_to_rdy", 64'(n), 64'(exp_cycles));
        if (rdy_at == n) begin
            s_rdy = 1'b1;
            tick();
            s_rdy = 1'b0;
        end
    endtask

    initial begin
        int m;
        repeat (2) tick();
        check("reset_outputs", outs(), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;

        // round robin with every master requesting
        m_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            m = k % 4;
            wait_gnt(m);
            do_txn(m, 8'(8'h10 + k), 2'b00, 8'h00, 1, 8'(8'h50 + k), 2, 1'b0, 1'b1);
        end
        m_req = '0;

        // plain read and write
        m_req = 4'b0100;
        wait_gnt(2);
        do_txn(2, 8'h3C, 2'b00, 8'h00, 2, 8'hA5, 3, 1'b0, 1'b0);
        m_req = 4'b1000;
        wait_gnt(3);
        do_txn(3, 8'h77, 2'b01, 8'h99, 0, 8'h12, 1, 1'b0, 1'b0);

        // timeout, s_rdy on the last allowed cycle, s_rdy one cycle too late
        m_req = 4'b0001;
        wait_gnt(0);
        do_txn(0, 8'h40, 2'b00, 8'h00, -1, 8'hFF, 15, 1'b1, 1'b0);
        m_req = 4'b0010;
        wait_gnt(1);
        do_txn(1, 8'h41, 2'b00, 8'h00, 14, 8'hC3, 15, 1'b0, 1'b0);
        m_req = 4'b0100;
        wait_gnt(2);
        do_txn(2, 8'h42, 2'b01, 8'h5F, 15, 8'hEE, 15, 1'b1, 1'b0);

        // reserved mode
        m_req = 4'b1000;
        wait_gnt(3);
        rdy_q.push_back({1'b0, 4'b1000, 1'b1, 8'h00});
        m_addr[3]  = 8'hEE;
        m_mode[3]  = 2'b10;
        m_start[3] = 1'b1;
        tick();
        m_start[3] = 1'b0;
        m_req      = '0;
        check("rsv_rdy", 64'(m_rdy), 64'(4'b1000));
        check("rsv_err", 64'(m_err), 64'(1));
        check("rsv_no_s_start", 64'(s_start), 64'(0));

        // owner drops request; last_owner must still advance
        m_req = 4'b0011;
        wait_gnt(0);
        m_req = 4'b0010;
        tick();
        check("drop_gnt", 64'(m_gnt), 64'(0));
        check("drop_s_req", 64'(s_req), 64'(0));
        m_req = 4'b0011;
        wait_gnt(1);
        m_req = 4'b0010;

        // non-owner start is ignored
        m_addr[0]  = 8'hDD;
        m_mode[0]  = 2'b00;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        check("nonowner_no_s_start", 64'(s_start), 64'(0));
        check("nonowner_state", 64'(dbg_state), 64'(GRANTED));

        // start held while s_gnt is low for three cycles
        start_q.push_back({8'h5A, 2'b00, 8'h00});
        rdy_q.push_back({1'b1, 4'b0010, 1'b0, 8'h3E});
        s_gnt      = 1'b0;
        m_addr[1]  = 8'h5A;
        m_mode[1]  = 2'b00;
        m_wdata[1] = 8'h00;
        m_start[1] = 1'b1;
        tick();
        m_start[1] = 1'b0;
        m_req      = '0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            check("held_no_s_start", 64'(s_start), 64'(0));
        end
        s_gnt = 1'b1;
        tick();
        check("s_start_after_s_gnt", 64'(s_start), 64'(1));
        s_rdy   = 1'b1;
        s_rdata = 8'h3E;
        tick();
        s_rdy = 1'b0;
        check("held_rdy", 64'(m_rdy), 64'(4'b0010));

        // reset in the middle of a busy transfer
        m_req = 4'b0001;
        wait_gnt(0);
        start_q.push_back({8'h81, 2'b00, 8'h00});
        m_addr[0]  = 8'h81;
        m_mode[0]  = 2'b00;
        m_wdata[0] = 8'h00;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        m_req      = '0;
        repeat (3) tick();
        check("busy_before_reset", 64'(dbg_state), 64'(BUSY));
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", outs(), 64'(0));
        tick();
        check("reset_held_outputs", outs(), 64'(0));
        check("reset_held_state", 64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;
        m_req = 4'b1111;
        wait_gnt(0);
        m_req = '0;
        repeat (4) tick();

        check("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
        check("start_q_drained", 64'(start_q.size()), 64'(0));
        check("rdy_q_drained", 64'(rdy_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
